// File: rtl/core_alu_decoder.sv
// core_alu_decoder: RV32I instruction word -> registered ALU control bundle with valid/ready and flush.
// Optional macro CORE_ALU_DEC_UNSUP_EN adds a registered unsupported-encoding flag on unsup_o.

package core_pkg;
  parameter int unsigned DATA_WIDTH     = 32;
  parameter int unsigned ALU_WIDTH_CODE = 4;
endpackage

package alu_control_pkg;
  typedef enum logic [core_pkg::ALU_WIDTH_CODE-1:0] {
    alu_add  = 4'd0,
    alu_sub  = 4'd1,
    alu_and  = 4'd2,
    alu_xor  = 4'd3,
    alu_or   = 4'd4,
    alu_slt  = 4'd5,
    alu_sltu = 4'd6,
    alu_none = 4'd7
  } alu_op_e;
endpackage

module core_alu_decoder
  import alu_control_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = core_pkg::DATA_WIDTH,
  parameter int unsigned ALU_WIDTH_CODE = core_pkg::ALU_WIDTH_CODE
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [31:0]               instr_i,
  input  logic [DATA_WIDTH-1:0]     pc_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [ALU_WIDTH_CODE-1:0] alu_control_o,
  output logic [1:0]                op_a_sel_o,
  output logic                      op_b_sel_o,
  output logic [DATA_WIDTH-1:0]     imm_o,
  output logic [DATA_WIDTH-1:0]     pc_o,
  output logic [4:0]                rs1_o,
  output logic [4:0]                rs2_o,
  output logic [4:0]                rd_o,
  output logic                      reg_write_o,
  output logic                      unsup_o
);

  typedef enum logic [6:0] {
    OPC_OP     = 7'b0110011,
    OPC_OP_IMM = 7'b0010011,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011
  } opcode_e;

  opcode_e               opcode;
  logic [2:0]            funct3;
  logic [6:0]            funct7;
  logic [DATA_WIDTH-1:0] imm_i_type;
  logic [DATA_WIDTH-1:0] imm_s_type;
  logic [DATA_WIDTH-1:0] imm_u_type;

  assign opcode     = opcode_e'(instr_i[6:0]);
  assign funct3     = instr_i[14:12];
  assign funct7     = instr_i[31:25];
  assign imm_i_type = DATA_WIDTH'($signed(instr_i[31:20]));
  assign imm_s_type = DATA_WIDTH'($signed({instr_i[31:25], instr_i[11:7]}));
  assign imm_u_type = DATA_WIDTH'($signed({instr_i[31:12], 12'b0}));

  alu_op_e               dec_alu;
  logic [1:0]            dec_a_sel;
  logic                  dec_b_sel;
  logic [DATA_WIDTH-1:0] dec_imm;
  logic                  dec_wr;
  logic                  dec_ok;

  always_comb begin
    dec_alu   = alu_none;
    dec_a_sel = 2'd0;
    dec_b_sel = 1'b0;
    dec_imm   = '0;
    dec_wr    = 1'b0;
    dec_ok    = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_wr = 1'b1;
        if (funct7 == 7'b0000000) begin
          dec_ok = 1'b1;
          case (funct3)
            3'b000:  dec_alu = alu_add;
            3'b100:  dec_alu = alu_xor;
            3'b110:  dec_alu = alu_or;
            3'b111:  dec_alu = alu_and;
            3'b010:  dec_alu = alu_slt;
            3'b011:  dec_alu = alu_sltu;
            default: dec_ok  = 1'b0;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          dec_ok  = 1'b1;
          dec_alu = alu_sub;
        end
      end
      OPC_OP_IMM: begin
        dec_ok    = 1'b1;
        dec_wr    = 1'b1;
        dec_b_sel = 1'b1;
        dec_imm   = imm_i_type;
        case (funct3)
          3'b000:  dec_alu = alu_add;
          3'b010:  dec_alu = alu_slt;
          3'b011:  dec_alu = alu_sltu;
          3'b100:  dec_alu = alu_xor;
          3'b110:  dec_alu = alu_or;
          3'b111:  dec_alu = alu_and;
          default: dec_ok  = 1'b0;
        endcase
      end
      OPC_LUI: begin
        dec_ok    = 1'b1;
        dec_wr    = 1'b1;
        dec_alu   = alu_add;
        dec_a_sel = 2'd2;
        dec_b_sel = 1'b1;
        dec_imm   = imm_u_type;
      end
      OPC_AUIPC: begin
        dec_ok    = 1'b1;
        dec_wr    = 1'b1;
        dec_alu   = alu_add;
        dec_a_sel = 2'd1;
        dec_b_sel = 1'b1;
        dec_imm   = imm_u_type;
      end
      OPC_LOAD: begin
        dec_ok    = 1'b1;
        dec_wr    = 1'b1;
        dec_alu   = alu_add;
        dec_b_sel = 1'b1;
        dec_imm   = imm_i_type;
      end
      OPC_STORE: begin
        dec_ok    = 1'b1;
        dec_alu   = alu_add;
        dec_b_sel = 1'b1;
        dec_imm   = imm_s_type;
      end
      default: dec_ok = 1'b0;
    endcase
    // Partially decoded fields (shift funct3, M-ext funct7) are scrubbed back to the idle bundle here.
    if (!dec_ok) begin
      dec_alu   = alu_none;
      dec_a_sel = 2'd0;
      dec_b_sel = 1'b0;
      dec_imm   = '0;
    end
    dec_wr = dec_wr && dec_ok && (instr_i[11:7] != 5'd0);
  end

  logic                      valid_q;
  logic [ALU_WIDTH_CODE-1:0] alu_q;
  logic [1:0]                a_sel_q;
  logic                      b_sel_q;
  logic [DATA_WIDTH-1:0]     imm_q;
  logic [DATA_WIDTH-1:0]     pc_q;
  logic [4:0]                rs1_q;
  logic [4:0]                rs2_q;
  logic [4:0]                rd_q;
  logic                      wr_q;
  logic                      accept;

  assign in_ready_o = !valid_q || out_ready_i;
  assign accept     = in_valid_i && in_ready_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      alu_q   <= ALU_WIDTH_CODE'(alu_none);
      a_sel_q <= '0;
      b_sel_q <= 1'b0;
      imm_q   <= '0;
      pc_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      wr_q    <= 1'b0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      alu_q   <= ALU_WIDTH_CODE'(dec_alu);
      a_sel_q <= dec_a_sel;
      b_sel_q <= dec_b_sel;
      imm_q   <= dec_imm;
      pc_q    <= pc_i;
      rs1_q   <= instr_i[19:15];
      rs2_q   <= instr_i[24:20];
      rd_q    <= instr_i[11:7];
      wr_q    <= dec_wr;
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
    end
  end

`ifdef CORE_ALU_DEC_UNSUP_EN
  logic unsup_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      unsup_q <= 1'b0;
    end else if (flush_i) begin
      unsup_q <= 1'b0;
    end else if (accept) begin
      unsup_q <= !dec_ok;
    end else if (out_ready_i) begin
      unsup_q <= 1'b0;
    end
  end

  assign unsup_o = unsup_q;
`else
  assign unsup_o = 1'b0;
`endif

  assign out_valid_o   = valid_q;
  assign alu_control_o = alu_q;
  assign op_a_sel_o    = a_sel_q;
  assign op_b_sel_o    = b_sel_q;
  assign imm_o         = imm_q;
  assign pc_o          = pc_q;
  assign rs1_o         = rs1_q;
  assign rs2_o         = rs2_q;
  assign rd_o          = rd_q;
  assign reg_write_o   = wr_q;

endmodule

// File: tb/tb_core_alu_decoder.sv
// Directed self-checking bench for core_alu_decoder: reset, decode table, back-to-back, stall, flush.
// Honours CORE_ALU_DEC_UNSUP_EN to choose the expected unsup_o behaviour.
module tb_core_alu_decoder;
  import alu_control_pkg::*;

`ifdef CORE_ALU_DEC_UNSUP_EN
  localparam bit UNSUP_EN = 1'b1;
`else
  localparam bit UNSUP_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] instr_i;
  logic [31:0] pc_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [3:0]  alu_control_o;
  logic [1:0]  op_a_sel_o;
  logic        op_b_sel_o;
  logic [31:0] imm_o;
  logic [31:0] pc_o;
  logic [4:0]  rs1_o;
  logic [4:0]  rs2_o;
  logic [4:0]  rd_o;
  logic        reg_write_o;
  logic        unsup_o;

  int checks   = 0;
  int failures = 0;

  core_alu_decoder #(.DATA_WIDTH(32), .ALU_WIDTH_CODE(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .instr_i(instr_i), .pc_i(pc_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .alu_control_o(alu_control_o), .op_a_sel_o(op_a_sel_o), .op_b_sel_o(op_b_sel_o),
    .imm_o(imm_o), .pc_o(pc_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o),
    .reg_write_o(reg_write_o), .unsup_o(unsup_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] instr;
    alu_op_e     alu;
    logic [1:0]  a;
    logic        b;
    logic [31:0] imm;
    logic        wr;
    logic        uns;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } vec_t;

  task automatic test_reset();
    rst_n = 1'b0; flush_i = 1'b0; out_ready_i = 1'b1;
    in_valid_i = 1'b1; instr_i = 32'hFFF00093; pc_i = 32'h0000_0040;
    repeat (3) @(negedge clk);
    checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid_o); end
    checks++; if (alu_control_o !== alu_none) begin failures++; $display("FAIL reset_alu got=%0d exp=%0d", alu_control_o, alu_none); end
    checks++; if ({imm_o, pc_o} !== 64'd0) begin failures++; $display("FAIL reset_imm_pc got=%h/%h exp=0/0", imm_o, pc_o); end
    checks++; if ({rs1_o, rs2_o, rd_o, reg_write_o, op_a_sel_o, op_b_sel_o, unsup_o} !== 20'd0) begin
      failures++; $display("FAIL reset_fields got=%h exp=0", {rs1_o, rs2_o, rd_o, reg_write_o, op_a_sel_o, op_b_sel_o, unsup_o});
    end
    in_valid_i = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready_o); end
    checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL reset_release_valid got=%b exp=0", out_valid_o); end
  endtask

  task automatic test_decode();
    vec_t v[16];
    v[0]  = '{32'hFFF00093, alu_add,  2'd0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 5'd0, 5'd31, 5'd1};
    v[1]  = '{32'h12345137, alu_add,  2'd2, 1'b1, 32'h12345000, 1'b1, 1'b0, 5'd8, 5'd3,  5'd2};
    v[2]  = '{32'h00000013, alu_add,  2'd0, 1'b1, 32'h00000000, 1'b0, 1'b0, 5'd0, 5'd0,  5'd0};
    v[3]  = '{32'h0020A423, alu_add,  2'd0, 1'b1, 32'h00000008, 1'b0, 1'b0, 5'd1, 5'd2,  5'd8};
    v[4]  = '{32'hFE20AE23, alu_add,  2'd0, 1'b1, 32'hFFFFFFFC, 1'b0, 1'b0, 5'd1, 5'd2,  5'd28};
    v[5]  = '{32'h00001297, alu_add,  2'd1, 1'b1, 32'h00001000, 1'b1, 1'b0, 5'd0, 5'd0,  5'd5};
    v[6]  = '{32'hFFE12093, alu_slt,  2'd0, 1'b1, 32'hFFFFFFFE, 1'b1, 1'b0, 5'd2, 5'd30, 5'd1};
    v[7]  = '{32'h003130B3, alu_sltu, 2'd0, 1'b0, 32'h00000000, 1'b1, 1'b0, 5'd2, 5'd3,  5'd1};
    v[8]  = '{32'h0040A303, alu_add,  2'd0, 1'b1, 32'h00000004, 1'b1, 1'b0, 5'd1, 5'd4,  5'd6};
    v[9]  = '{32'h7FF14093, alu_xor,  2'd0, 1'b1, 32'h000007FF, 1'b1, 1'b0, 5'd2, 5'd31, 5'd1};
    v[10] = '{32'h003170B3, alu_and,  2'd0, 1'b0, 32'h00000000, 1'b1, 1'b0, 5'd2, 5'd3,  5'd1};
    v[11] = '{32'h003160B3, alu_or,   2'd0, 1'b0, 32'h00000000, 1'b1, 1'b0, 5'd2, 5'd3,  5'd1};
    v[12] = '{32'h001090B3, alu_none, 2'd0, 1'b0, 32'h00000000, 1'b0, 1'b1, 5'd1, 5'd1,  5'd1};
    v[13] = '{32'h023100B3, alu_none, 2'd0, 1'b0, 32'h00000000, 1'b0, 1'b1, 5'd2, 5'd3,  5'd1};
    v[14] = '{32'h403140B3, alu_none, 2'd0, 1'b0, 32'h00000000, 1'b0, 1'b1, 5'd2, 5'd3,  5'd1};
    v[15] = '{32'h00208063, alu_none, 2'd0, 1'b0, 32'h00000000, 1'b0, 1'b1, 5'd1, 5'd2,  5'd0};
    out_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid_i = 1'b1; instr_i = v[i].instr; pc_i = 32'h1000 + 32'(i * 4);
      checks++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL dec%0d_in_ready got=%b exp=1", i, in_ready_o); end
      @(negedge clk);
      checks++; if (out_valid_o !== 1'b1) begin failures++; $display("FAIL dec%0d_valid got=%b exp=1", i, out_valid_o); end
      checks++; if (alu_control_o !== v[i].alu) begin failures++; $display("FAIL dec%0d_alu got=%0d exp=%0d", i, alu_control_o, v[i].alu); end
      checks++; if ({op_a_sel_o, op_b_sel_o} !== {v[i].a, v[i].b}) begin
        failures++; $display("FAIL dec%0d_sel got=%0d/%0d exp=%0d/%0d", i, op_a_sel_o, op_b_sel_o, v[i].a, v[i].b);
      end
      checks++; if (imm_o !== v[i].imm) begin failures++; $display("FAIL dec%0d_imm got=%h exp=%h", i, imm_o, v[i].imm); end
      checks++; if (reg_write_o !== v[i].wr) begin failures++; $display("FAIL dec%0d_wr got=%b exp=%b", i, reg_write_o, v[i].wr); end
      checks++; if (unsup_o !== (v[i].uns & UNSUP_EN)) begin failures++; $display("FAIL dec%0d_unsup got=%b exp=%b", i, unsup_o, v[i].uns & UNSUP_EN); end
      checks++; if ({rs1_o, rs2_o, rd_o} !== {v[i].rs1, v[i].rs2, v[i].rd}) begin
        failures++; $display("FAIL dec%0d_regs got=%0d/%0d/%0d exp=%0d/%0d/%0d", i, rs1_o, rs2_o, rd_o, v[i].rs1, v[i].rs2, v[i].rd);
      end
      checks++; if (pc_o !== 32'h1000 + 32'(i * 4)) begin failures++; $display("FAIL dec%0d_pc got=%h exp=%h", i, pc_o, 32'h1000 + 32'(i * 4)); end
    end
    in_valid_i = 1'b0;
    @(negedge clk);
    checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL consume_valid got=%b exp=0", out_valid_o); end
    checks++; if (unsup_o !== 1'b0) begin failures++; $display("FAIL consume_unsup got=%b exp=0", unsup_o); end
    checks++; if (pc_o !== 32'h103C) begin failures++; $display("FAIL consume_hold_pc got=%h exp=103c", pc_o); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    out_ready_i = 1'b1; in_valid_i = 1'b1; instr_i = 32'h002081B3; pc_i = 32'h100;
    @(negedge clk);
    checks++; if (out_valid_o !== 1'b1 || alu_control_o !== alu_add) begin
      failures++; $display("FAIL b2b_first got=%b/%0d exp=1/%0d", out_valid_o, alu_control_o, alu_add);
    end
    checks++; if ({rs1_o, rs2_o, rd_o, op_a_sel_o, op_b_sel_o, reg_write_o} !== {5'd1, 5'd2, 5'd3, 2'd0, 1'b0, 1'b1}) begin
      failures++; $display("FAIL b2b_first_fields got=%0d/%0d/%0d/%0d/%0d/%0d exp=1/2/3/0/0/1", rs1_o, rs2_o, rd_o, op_a_sel_o, op_b_sel_o, reg_write_o);
    end
    instr_i = 32'h407302B3; pc_i = 32'h104;
    @(negedge clk);
    checks++; if (out_valid_o !== 1'b1 || alu_control_o !== alu_sub) begin
      failures++; $display("FAIL b2b_second got=%b/%0d exp=1/%0d", out_valid_o, alu_control_o, alu_sub);
    end
    checks++; if ({rs1_o, rs2_o, rd_o, pc_o} !== {5'd6, 5'd7, 5'd5, 32'h104}) begin
      failures++; $display("FAIL b2b_second_fields got=%0d/%0d/%0d/%h exp=6/7/5/104", rs1_o, rs2_o, rd_o, pc_o);
    end
    in_valid_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stall();
    out_ready_i = 1'b1; in_valid_i = 1'b1; instr_i = 32'h002081B3; pc_i = 32'h200;
    @(negedge clk);
    checks++; if (out_valid_o !== 1'b1 || pc_o !== 32'h200) begin failures++; $display("FAIL stall_load got=%b/%h exp=1/200", out_valid_o, pc_o); end
    instr_i = 32'h407302B3; pc_i = 32'h204; out_ready_i = 1'b0;
    #1;
    checks++; if (in_ready_o !== 1'b0) begin failures++; $display("FAIL stall_in_ready got=%b exp=0", in_ready_o); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if ({out_valid_o, in_ready_o, alu_control_o, rd_o, pc_o} !== {1'b1, 1'b0, 4'(alu_add), 5'd3, 32'h200}) begin
        failures++; $display("FAIL stall_hold%0d got=%b/%b/%0d/%0d/%h exp=1/0/%0d/3/200", i, out_valid_o, in_ready_o, alu_control_o, rd_o, pc_o, alu_add);
      end
    end
    out_ready_i = 1'b1;
    #1;
    checks++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL stall_release_ready got=%b exp=1", in_ready_o); end
    @(negedge clk);
    checks++; if ({out_valid_o, alu_control_o, rd_o, pc_o} !== {1'b1, 4'(alu_sub), 5'd5, 32'h204}) begin
      failures++; $display("FAIL stall_next got=%b/%0d/%0d/%h exp=1/%0d/5/204", out_valid_o, alu_control_o, rd_o, pc_o, alu_sub);
    end
    in_valid_i = 1'b0;
    @(negedge clk);
    checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL stall_drain got=%b exp=0", out_valid_o); end
  endtask

  task automatic test_flush();
    out_ready_i = 1'b0; in_valid_i = 1'b1; instr_i = 32'h001090B3; pc_i = 32'h300;
    @(negedge clk);
    checks++; if (out_valid_o !== 1'b1 || unsup_o !== UNSUP_EN) begin
      failures++; $display("FAIL flush_load got=%b/%b exp=1/%b", out_valid_o, unsup_o, UNSUP_EN);
    end
    instr_i = 32'h407302B3; pc_i = 32'h304; flush_i = 1'b1;
    #1;
    checks++; if (in_ready_o !== 1'b0) begin failures++; $display("FAIL flush_in_ready_stalled got=%b exp=0", in_ready_o); end
    @(negedge clk);
    flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    checks++; if (out_valid_o !== 1'b0 || unsup_o !== 1'b0) begin
      failures++; $display("FAIL flush_clear got=%b/%b exp=0/0", out_valid_o, unsup_o);
    end
    @(negedge clk);
    checks++; if ({out_valid_o, alu_control_o, pc_o} !== {1'b0, 4'(alu_none), 32'h300}) begin
      failures++; $display("FAIL flush_dropped got=%b/%0d/%h exp=0/%0d/300", out_valid_o, alu_control_o, pc_o, alu_none);
    end
    in_valid_i = 1'b1; instr_i = 32'h002081B3; pc_i = 32'h310; flush_i = 1'b1;
    #1;
    checks++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL flush_in_ready_idle got=%b exp=1", in_ready_o); end
    @(negedge clk);
    flush_i = 1'b0; in_valid_i = 1'b0;
    checks++; if (out_valid_o !== 1'b0 || pc_o !== 32'h300) begin
      failures++; $display("FAIL flush_accept_dropped got=%b/%h exp=0/300", out_valid_o, pc_o);
    end
  endtask

  task automatic test_reset_mid_stall();
    out_ready_i = 1'b0; in_valid_i = 1'b1; instr_i = 32'hFFF00093; pc_i = 32'h400;
    @(negedge clk);
    in_valid_i = 1'b0;
    checks++; if (out_valid_o !== 1'b1 || imm_o !== 32'hFFFFFFFF) begin
      failures++; $display("FAIL midrst_load got=%b/%h exp=1/ffffffff", out_valid_o, imm_o);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({out_valid_o, alu_control_o, imm_o, pc_o, rd_o, reg_write_o, op_b_sel_o} !== {1'b0, 4'(alu_none), 32'd0, 32'd0, 5'd0, 1'b0, 1'b0}) begin
      failures++; $display("FAIL midrst_clear got=%b/%0d/%h/%h/%0d/%b/%b exp=0/%0d/0/0/0/0/0", out_valid_o, alu_control_o, imm_o, pc_o, rd_o, reg_write_o, op_b_sel_o, alu_none);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
      failures++; $display("FAIL midrst_release got=%b/%b exp=1/0", in_ready_o, out_valid_o);
    end
  endtask

  initial begin
    flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    instr_i = '0; pc_i = '0; rst_n = 1'b0;
    test_reset();
    test_decode();
    test_back_to_back();
    test_stall();
    test_flush();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/core_alu_decoder.md
# core_alu_decoder

Pipelined instruction-to-ALU-control decoder between the fetch/decode register and the execution-stage ALU. It accepts one 32-bit RV32I instruction per valid/ready handshake and produces a registered bundle for the ALU and operand muxes: the `alu_control_pkg` opcode, operand selects, immediate, and register indices. It is the producer side of the `alu_control` interface the ALU consumes. It handles flush and backpressure so the execution stage can stall without losing instructions.

## Interface
- `DATA_WIDTH`, from `core_pkg` (32): datapath, PC and immediate width.
- `ALU_WIDTH_CODE`, from `core_pkg`: width of `alu_control`.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `flush_i` in 1: discard the held and incoming instruction.
- `in_valid_i` in 1: instruction present.
- `in_ready_o` out 1: decoder can accept.
- `instr_i` in 32: instruction word.
- `pc_i` in DATA_WIDTH: PC of the instruction.
- `out_valid_o` out 1: decoded bundle valid.
- `out_ready_i` in 1: execution stage accepts the bundle.
- `alu_control_o` out ALU_WIDTH_CODE: `alu_add`/`alu_sub`/`alu_and`/`alu_xor`/`alu_or`/`alu_slt`/`alu_sltu`/`alu_none`.
- `op_a_sel_o` out 2: operand A select. 0 = rs1, 1 = pc, 2 = zero.
- `op_b_sel_o` out 1: operand B select. 0 = rs2, 1 = imm.
- `imm_o` out DATA_WIDTH: sign-extended immediate.
- `pc_o` out DATA_WIDTH: registered PC.
- `rs1_o`, `rs2_o`, `rd_o` out 5 each: register indices.
- `reg_write_o` out 1: write rd.
- `unsup_o` out 1: instruction not handled by this block (only with macro, see Configuration).

## Operation
- Single output register stage. `in_ready_o = !out_valid_o || out_ready_i` (combinational).
- Transfer occurs when `in_valid_i && in_ready_o`. The decoded bundle loads and `out_valid_o` sets.
- If the output is consumed and no new input arrives, `out_valid_o` clears. Bundle fields hold their last value.
- While `out_valid_o && !out_ready_i`, all outputs hold stable.
- Decode, by opcode `instr[6:0]`:
  - OP 0110011 with funct7 = 0000000, by funct3:
    - 000 → add
    - 100 → xor
    - 110 → or
    - 111 → and
    - 010 → slt
    - 011 → sltu
  - OP 0110011 with funct7 = 0100000, funct3 = 000 → sub.
  - OP: sel A = 0, B = 0, `reg_write` set.
  - OP-IMM 0010011, by funct3:
    - 000 → add
    - 010 → slt
    - 011 → sltu
    - 100 → xor
    - 110 → or
    - 111 → and
  - OP-IMM: I-immediate, A = 0, B = 1, `reg_write` set.
  - LUI 0110111: add, A = 2, B = 1, U-immediate (`instr[31:12] << 12`), `reg_write` set.
  - AUIPC 0010111: add, A = 1, B = 1, U-immediate, `reg_write` set.
  - LOAD 0000011: add, A = 0, B = 1, I-immediate, `reg_write` set.
  - STORE 0100011: add, A = 0, B = 1, S-immediate, `reg_write` clear.
  - Anything else (shifts, funct3 001/101, M-extension funct7, branches, JAL/JALR, SYSTEM): `alu_control = alu_none`, selects 0, imm 0, `reg_write` 0, unsupported.
- `reg_write_o` is forced to 0 when rd = 0.
- `rs1/rs2/rd` are always the raw fields `instr[19:15]`, `[24:20]`, `[11:7]`.

## Timing
- Latency is 1 cycle, input accept edge to `out_valid_o`. Throughput is 1 instruction/cycle when `out_ready_i` is held high.
- Reset (asynchronous assert, any time, including mid-stall):
  - `out_valid_o` = 0
  - `alu_control_o` = `alu_none`
  - all other outputs = 0
- `in_ready_o` = 1 in the first cycle after reset release.
- `flush_i` has priority over everything. On the flush edge `out_valid_o` clears, and any simultaneously accepted input is dropped (not loaded). `in_ready_o` is still computed normally during the flush cycle.
- Simultaneous consume and accept: the new bundle replaces the old one on the same edge, and `out_valid_o` stays 1.

## Configuration
- Macro `CORE_ALU_DEC_UNSUP_EN`.
- Defined: `unsup_o` is registered with the bundle and is 1 for every unsupported encoding. It resets to 0, and clears on flush and on consume.
- Undefined: `unsup_o` is tied to 0. Unsupported encodings still decode to `alu_none` with `reg_write` 0.

## Test plan
- Reset with `in_valid_i` = 1 during reset → `out_valid_o` = 0, `alu_control_o` = `alu_none`. After release, `in_ready_o` = 1.
- Back-to-back, ready high: `0x002081B3` (add x3,x1,x2) then `0x407302B3` (sub x5,x6,x7).
  - First bundle: `alu_add`, rs1 = 1, rs2 = 2, rd = 3, sel A = 0, B = 0, `reg_write` = 1.
  - Second bundle, next cycle: `alu_sub`, rd = 5, rs2 = 7.
- `0xFFF00093` (addi x1,x0,-1) → `imm_o` = 0xFFFFFFFF, B = 1. `0x12345137` (lui x2) → imm = 0x12345000, A = 2, `alu_add`.
- `0x00000013` (addi x0,x0,0) → `reg_write_o` = 0. `0x001090B3` (sll) → `alu_none`, and `unsup_o` = 1 only with the macro.
- Stall: `out_ready_i` = 0 for 3 cycles with `in_valid_i` held.
  - `in_ready_o` = 0 and outputs stable throughout.
  - On release, the held bundle transfers and the next instruction loads on the same edge.
- Flush during stall with a new `in_valid_i` → next cycle `out_valid_o` = 0, and the new instruction never appears.
